ram64_arbiter: RTL and testbench

// - Shares one RAM64 (16-bit x 64, write at clk edge when load=1, out combinational on address) between two requesters.
// - Round-robin, one transaction per cycle, valid/ready request handshake, registered read response.
// - Sits between the RAM64 instance and two masters (e.g. CPU data port and a DMA/loader engine).

---
 rtl/ram64_arb_pkg.sv | 16 +
 rtl/rr_arb2.sv | 40 ++++
 rtl/ram64_arbiter.sv | 145 ++++++++++++++
 tb/tb_ram64_arbiter.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram64_arb_pkg.sv
// rtl/ram64_arb_pkg.sv - shared constants, state encoding and requester ids for the RAM64 arbiter
package ram64_arb_pkg;

    localparam int WIDTH     = 16;
    localparam int ADDR_W    = 6;
    localparam int NUM_WORDS = 64;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin arbiter with a last-grant register
module rr_arb2
    import ram64_arb_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] valid,
    input  logic       advance,
    output logic [1:0] grant
);

    logic last_grant_q;
    logic last_grant_d;

    // A lone requester always wins; on contention the one not served last wins.
    always_comb begin
        grant = valid;
        if (valid == 2'b11) begin
            grant = (last_grant_q == REQ1) ? 2'b01 : 2'b10;
        end
    end

    // Remember who was served, but only when a transaction actually completed.
    always_comb begin
        last_grant_d = last_grant_q;
        if (advance) begin
            last_grant_d = grant[1] ? REQ1 : REQ0;
        end
    end

    // Starting from REQ1 lets requester 0 win the first contention.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant_q <= REQ1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/ram64_arbiter.sv
// rtl/ram64_arbiter.sv - two-requester round-robin front end for RAM64; RAM64_ARB_CLEAR_ON_RESET_EN adds a zeroing sweep after reset
module ram64_arbiter #(
    parameter int WIDTH  = ram64_arb_pkg::WIDTH,
    parameter int ADDR_W = ram64_arb_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic              req0_we,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [WIDTH-1:0]  req0_wdata,
    output logic              rsp0_valid,
    output logic [WIDTH-1:0]  rsp0_rdata,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_we,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [WIDTH-1:0]  req1_wdata,
    output logic              rsp1_valid,
    output logic [WIDTH-1:0]  rsp1_rdata,
    output logic [WIDTH-1:0]  ram_in,
    output logic              ram_load,
    output logic [ADDR_W-1:0] ram_address,
    input  logic [WIDTH-1:0]  ram_out,
    output logic              busy
);
    import ram64_arb_pkg::*;

    logic [1:0]       grant;
    logic             accept_en;
    logic             handshake;

    logic             rsp0_valid_q, rsp0_valid_d;
    logic             rsp1_valid_q, rsp1_valid_d;
    logic [WIDTH-1:0] rsp0_rdata_q, rsp0_rdata_d;
    logic [WIDTH-1:0] rsp1_rdata_q, rsp1_rdata_d;

`ifdef RAM64_ARB_CLEAR_ON_RESET_EN
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_WORDS - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              clearing;

    // Sweep every word once, then drop into normal service.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_CLEAR: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_ADDR) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Every reset restarts the sweep from address 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Gated by reset so the RAM port sits idle while reset is held.
    assign clearing = (state_q == ST_CLEAR) & ~reset;
    assign busy     = clearing;
`else
    assign busy = 1'b0;
`endif

    // Nothing is accepted while reset is asserted or a sweep is running.
    assign accept_en  = ~reset & ~busy;
    assign req0_ready = grant[0] & req0_valid & accept_en;
    assign req1_ready = grant[1] & req1_valid & accept_en;
    assign handshake  = req0_ready | req1_ready;

    rr_arb2 u_rr_arb2 (
        .clk     (clk),
        .reset   (reset),
        .valid   ({req1_valid, req0_valid}),
        .advance (handshake),
        .grant   (grant)
    );

    // Drive the RAM from the sweep or the accepted request; park at zero otherwise.
    always_comb begin
        ram_load    = 1'b0;
        ram_address = '0;
        ram_in      = '0;
`ifdef RAM64_ARB_CLEAR_ON_RESET_EN
        if (clearing) begin
            ram_load    = 1'b1;
            ram_address = cnt_q;
        end else
`endif
        if (req0_ready) begin
            ram_load    = req0_we;
            ram_address = req0_addr;
            ram_in      = req0_wdata;
        end else if (req1_ready) begin
            ram_load    = req1_we;
            ram_address = req1_addr;
            ram_in      = req1_wdata;
        end
    end

    // Reads capture the combinational RAM output; rdata holds between responses.
    always_comb begin
        rsp0_valid_d = req0_ready & ~req0_we;
        rsp1_valid_d = req1_ready & ~req1_we;
        rsp0_rdata_d = rsp0_valid_d ? ram_out : rsp0_rdata_q;
        rsp1_rdata_d = rsp1_valid_d ? ram_out : rsp1_rdata_q;
    end

    // Reset drops any response that was about to be presented.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            rsp0_rdata_q <= '0;
            rsp1_rdata_q <= '0;
        end else begin
            rsp0_valid_q <= rsp0_valid_d;
            rsp1_valid_q <= rsp1_valid_d;
            rsp0_rdata_q <= rsp0_rdata_d;
            rsp1_rdata_q <= rsp1_rdata_d;
        end
    end

    assign rsp0_valid = rsp0_valid_q;
    assign rsp1_valid = rsp1_valid_q;
    assign rsp0_rdata = rsp0_rdata_q;
    assign rsp1_rdata = rsp1_rdata_q;

endmodule

// File: tb/tb_ram64_arbiter.sv
// tb/tb_ram64_arbiter.sv - self-checking bench for ram64_arbiter with a RAM64 model and a reference model
module tb_ram64_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req0_ready, req0_we;
    logic [5:0]  req0_addr;
    logic [15:0] req0_wdata;
    logic        rsp0_valid;
    logic [15:0] rsp0_rdata;
    logic        req1_valid, req1_ready, req1_we;
    logic [5:0]  req1_addr;
    logic [15:0] req1_wdata;
    logic        rsp1_valid;
    logic [15:0] rsp1_rdata;
    logic [15:0] ram_in;
    logic        ram_load;
    logic [5:0]  ram_address;
    logic [15:0] ram_out;
    logic        busy;

    int checks = 0;
    int errors = 0;

    ram64_arbiter dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
        .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
        .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
        .ram_in(ram_in), .ram_load(ram_load), .ram_address(ram_address),
        .ram_out(ram_out), .busy(busy)
    );

    always #5 clk = ~clk;

    // RAM64 stand-in: combinational read, write on the rising edge.
    logic [15:0] ram [64];
    logic        ram_clr;
    assign ram_out = ram[ram_address];
    always @(posedge clk) begin
        if (ram_clr) begin
            for (int i = 0; i < 64; i++) ram[i] <= '0;
        end else if (ram_load) begin
            ram[ram_address] <= ram_in;
        end
    end

    // Reference model: expected memory contents, last served id, response registers.
    logic [15:0] mem_m [64];
    int          lg_m;
    bit          rv_m [2];
    logic [15:0] rd_m [2];

    task automatic model_reset(input bit clear_mem);
        lg_m = 1;
        rv_m[0] = 0; rv_m[1] = 0;
        rd_m[0] = '0; rd_m[1] = '0;
        if (clear_mem) for (int i = 0; i < 64; i++) mem_m[i] = '0;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input bit v0, input bit we0, input logic [5:0] a0, input logic [15:0] d0,
                         input bit v1, input bit we1, input logic [5:0] a1, input logic [15:0] d1);
        req0_valid = v0; req0_we = we0; req0_addr = a0; req0_wdata = d0;
        req1_valid = v1; req1_we = we1; req1_addr = a1; req1_wdata = d1;
    endtask

    // One cycle: called just after a rising edge with inputs already driven.
    task automatic run_cycle(input string tag, output bit r0, output bit r1);
        bit          v [2];
        bit          we [2];
        logic [5:0]  a [2];
        logic [15:0] d [2];
        int          g;
        #3;
        v[0] = req0_valid; we[0] = req0_we; a[0] = req0_addr; d[0] = req0_wdata;
        v[1] = req1_valid; we[1] = req1_we; a[1] = req1_addr; d[1] = req1_wdata;
        g = -1;
        if (v[0] && v[1]) g = (lg_m == 0) ? 1 : 0;
        else if (v[0])    g = 0;
        else if (v[1])    g = 1;
        chk({tag, " ready0"}, req0_ready, g == 0);
        chk({tag, " ready1"}, req1_ready, g == 1);
        chk({tag, " ready_excl"}, req0_ready & req1_ready, 0);
        chk({tag, " ram_load"}, ram_load, (g >= 0) ? we[g] : 1'b0);
        chk({tag, " ram_address"}, ram_address, (g >= 0) ? a[g] : 6'd0);
        chk({tag, " ram_in"}, ram_in, (g >= 0) ? d[g] : 16'd0);
        r0 = req0_ready;
        r1 = req1_ready;
        @(posedge clk);
        #1;
        rv_m[0] = 0; rv_m[1] = 0;
        if (g >= 0) begin
            lg_m = g;
            if (we[g]) mem_m[a[g]] = d[g];
            else begin
                rv_m[g] = 1;
                rd_m[g] = mem_m[a[g]];
            end
        end
        chk({tag, " rsp0_valid"}, rsp0_valid, rv_m[0]);
        chk({tag, " rsp1_valid"}, rsp1_valid, rv_m[1]);
        chk({tag, " rsp0_rdata"}, rsp0_rdata, rd_m[0]);
        chk({tag, " rsp1_rdata"}, rsp1_rdata, rd_m[1]);
    endtask

    // Called just after a rising edge with reset released: checks the whole zeroing sweep.
    task automatic sweep_check();
`ifdef RAM64_ARB_CLEAR_ON_RESET_EN
        for (int k = 0; k < 64; k++) begin
            #3;
            chk("sweep busy", busy, 1'b1);
            chk("sweep ready", {req1_ready, req0_ready}, 2'b00);
            chk("sweep ram_load", ram_load, 1'b1);
            chk("sweep ram_address", ram_address, k[5:0]);
            chk("sweep ram_in", ram_in, 16'd0);
            @(posedge clk);
            #1;
        end
        chk("sweep done busy", busy, 1'b0);
        for (int i = 0; i < 64; i++) mem_m[i] = '0;
`endif
    endtask

    typedef struct {
        bit v0; bit we0; logic [5:0] a0; logic [15:0] d0;
        bit v1; bit we1; logic [5:0] a1; logic [15:0] d1;
        bit r0; bit r1;
        bit rv0; logic [15:0] rd0;
        bit rv1; logic [15:0] rd1;
    } vec_t;

    function automatic vec_t mk(input bit v0, we0, input logic [5:0] a0, input logic [15:0] d0,
                                input bit v1, we1, input logic [5:0] a1, input logic [15:0] d1,
                                input bit r0, r1, input bit rv0, input logic [15:0] rd0,
                                input bit rv1, input logic [15:0] rd1);
        vec_t t;
        t.v0 = v0; t.we0 = we0; t.a0 = a0; t.d0 = d0;
        t.v1 = v1; t.we1 = we1; t.a1 = a1; t.d1 = d1;
        t.r0 = r0; t.r1 = r1; t.rv0 = rv0; t.rd0 = rd0; t.rv1 = rv1; t.rd1 = rd1;
        return t;
    endfunction

    vec_t tbl [$];

    initial begin
        bit r0, r1;
        string tag;

        // Directed vectors, expectations worked out by hand from the arbitration rules.
        tbl.push_back(mk(1,1, 4,16'd4,      0,0, 0,0,          1,0, 0,0,         0,0));
        tbl.push_back(mk(1,0, 4,0,          0,0, 0,0,          1,0, 1,16'd4,     0,0));
        tbl.push_back(mk(0,0, 0,0,          0,0, 0,0,          0,0, 0,0,         0,0));
        tbl.push_back(mk(0,0, 0,0,          1,0, 4,0,          0,1, 0,0,         1,16'd4));
        for (int k = 0; k < 3; k++) begin
            tbl.push_back(mk(1,0, 4,0,      1,0, 5,0,          1,0, 1,16'd4,     0,0));
            tbl.push_back(mk(1,0, 4,0,      1,0, 5,0,          0,1, 0,0,         1,16'd0));
        end
        tbl.push_back(mk(0,0, 0,0,          1,1, 63,16'hBEEF,  0,1, 0,0,         0,0));
        tbl.push_back(mk(1,0, 63,0,         0,0, 0,0,          1,0, 1,16'hBEEF,  0,0));
        tbl.push_back(mk(1,1, 12,16'h0011,  0,0, 0,0,          1,0, 0,0,         0,0));
        tbl.push_back(mk(0,0, 0,0,          1,1, 13,16'h1313,  0,1, 0,0,         0,0));
        tbl.push_back(mk(1,0, 12,0,         1,1, 12,16'h2222,  1,0, 1,16'h0011,  0,0));
        tbl.push_back(mk(0,0, 0,0,          1,1, 12,16'h2222,  0,1, 0,0,         0,0));
        tbl.push_back(mk(1,0, 12,0,         0,0, 0,0,          1,0, 1,16'h2222,  0,0));
        tbl.push_back(mk(0,0, 0,0,          1,0, 13,0,         0,1, 0,0,         1,16'h1313));

        // Reset with both requesters asserting valid: nothing may be accepted.
        reset = 1'b1;
        ram_clr = 1'b1;
        drive(1, 1, 6'd7, 16'h7777, 1, 1, 6'd8, 16'h8888);
        model_reset(1);
        @(posedge clk);
        @(posedge clk);
        #1;
        ram_clr = 1'b0;
        chk("reset ready", {req1_ready, req0_ready}, 2'b00);
        chk("reset rsp_valid", {rsp1_valid, rsp0_valid}, 2'b00);
        chk("reset rsp0_rdata", rsp0_rdata, 16'd0);
        chk("reset rsp1_rdata", rsp1_rdata, 16'd0);
        chk("reset ram_load", ram_load, 1'b0);
        chk("reset ram_address", ram_address, 6'd0);
        chk("reset ram_in", ram_in, 16'd0);
        reset = 1'b0;
        sweep_check();

        for (int i = 0; i < tbl.size(); i++) begin
            tag = $sformatf("vec%0d", i);
            drive(tbl[i].v0, tbl[i].we0, tbl[i].a0, tbl[i].d0,
                  tbl[i].v1, tbl[i].we1, tbl[i].a1, tbl[i].d1);
            run_cycle(tag, r0, r1);
            chk({tag, " tbl ready"}, {r1, r0}, {tbl[i].r1, tbl[i].r0});
            chk({tag, " tbl rsp_valid"}, {rsp1_valid, rsp0_valid}, {tbl[i].rv1, tbl[i].rv0});
            if (tbl[i].rv0) chk({tag, " tbl rsp0_rdata"}, rsp0_rdata, tbl[i].rd0);
            if (tbl[i].rv1) chk({tag, " tbl rsp1_rdata"}, rsp1_rdata, tbl[i].rd1);
        end

        // Asynchronous reset in the cycle right after a read handshake.
        drive(1, 0, 6'd12, 0, 0, 0, 0, 0);
        run_cycle("pre_reset_read", r0, r1);
        chk("pre_reset rsp0_valid", rsp0_valid, 1'b1);
        drive(1, 0, 6'd4, 0, 1, 0, 6'd5, 0);
        #2;
        reset = 1'b1;
        #1;
        chk("async rsp0_valid", rsp0_valid, 1'b0);
        chk("async rsp0_rdata", rsp0_rdata, 16'd0);
        chk("async rsp1_rdata", rsp1_rdata, 16'd0);
        chk("async ready", {req1_ready, req0_ready}, 2'b00);
        chk("async ram_load", ram_load, 1'b0);
        chk("async ram_address", ram_address, 6'd0);
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            #1;
            chk("held reset rsp0_valid", rsp0_valid, 1'b0);
        end
        reset = 1'b0;
        model_reset(0);
        sweep_check();
        drive(1, 0, 6'd4, 0, 1, 0, 6'd5, 0);
        run_cycle("post_reset first", r0, r1);
        chk("post_reset req0 wins", r0, 1'b1);

        // Random traffic over a small address window so conflicts are frequent.
        for (int n = 0; n < 300; n++) begin
            drive($urandom_range(0, 1), $urandom_range(0, 1), 6'($urandom_range(0, 7)), 16'($urandom),
                  $urandom_range(0, 1), $urandom_range(0, 1), 6'($urandom_range(0, 7)), 16'($urandom));
            run_cycle("rand", r0, r1);
        end

`ifdef RAM64_ARB_CLEAR_ON_RESET_EN
        // Preload, reset, and confirm the sweep wiped the preloaded words.
        drive(1, 1, 6'd0, 16'h1111, 1, 1, 6'd35, 16'h3535);
        run_cycle("preload a", r0, r1);
        run_cycle("preload b", r0, r1);
        drive(1, 1, 6'd63, 16'h6363, 0, 0, 0, 0);
        run_cycle("preload c", r0, r1);
        drive(1, 0, 6'd0, 0, 1, 0, 6'd35, 0);
        #2;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset(0);
        sweep_check();
        drive(1, 0, 6'd0, 0, 0, 0, 0, 0);
        run_cycle("clr read0", r0, r1);
        chk("clr addr0", rsp0_rdata, 16'd0);
        drive(0, 0, 0, 0, 1, 0, 6'd35, 0);
        run_cycle("clr read35", r0, r1);
        chk("clr addr35", rsp1_rdata, 16'd0);
        drive(1, 0, 6'd63, 0, 0, 0, 0, 0);
        run_cycle("clr read63", r0, r1);
        chk("clr addr63", rsp0_rdata, 16'd0);
`endif

        drive(0, 0, 0, 0, 0, 0, 0, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
